// File: rtl/pencoder_scan_disp.sv
// -----------------------------------------------------------------------------
// pencoder_scan_disp
//
// Registered priority encoder driving a time-multiplexed, active-low hex
// 7-segment display.
//
// The request vector is registered into in_q. On the next edge in_q is
// encoded to the index of its highest set bit, together with a valid flag.
// A free-running divider steps a digit pointer. Each cycle the pointer and
// the encoded index produce the registered segment and anode outputs.
//
// Optional feature:
//   PENC_LSB_PRIO_EN - when defined, the lowest set bit wins instead of the
//                      highest. Nothing else changes.
//
// Ports:
//   clk    - system clock; all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   en     - encoder enable; low forces idx=0, valid=0
//   hold   - while high (and en high), idx/valid keep their value
//   in     - request vector; bit IN_W-1 has the highest priority
//   idx    - registered encoded index
//   valid  - registered: at least one request bit set and en high
//   seg    - active-low segments {g,f,e,d,c,b,a}, registered
//   an     - active-low digit enables, one-hot-low, registered
// -----------------------------------------------------------------------------
module pencoder_scan_disp #(
    parameter int IN_W     = 16,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      hold,
    input  logic [IN_W-1:0]           in,
    output logic [$clog2(IN_W)-1:0]   idx,
    output logic                      valid,
    output logic [6:0]                seg,
    output logic [DIGITS-1:0]         an
);

    localparam int IDX_W = $clog2(IN_W);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [IN_W-1:0]     in_q,    in_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic                valid_q, valid_d;
    logic [DIV_W-1:0]    div_q,   div_d;
    logic [PTR_W-1:0]    ptr_q,   ptr_d;
    logic [6:0]          seg_q,   seg_d;
    logic [DIGITS-1:0]   an_q,    an_d;

    logic [IDX_W-1:0]    enc;
    logic [4*DIGITS-1:0] idx_ext;
    logic [3:0]          nibble;

    // Priority encoder over the registered request vector.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path leaves it unassigned; otherwise a latch is inferred.
        enc = '0;
`ifdef PENC_LSB_PRIO_EN
        // Scan downward so the lowest set bit is written last and wins.
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (in_q[i]) enc = IDX_W'(i);
        end
`else
        // Scan upward so the highest set bit is written last and wins.
        for (int i = 0; i < IN_W; i++) begin
            if (in_q[i]) enc = IDX_W'(i);
        end
`endif
    end

    // Next-state logic for the encoder stages.
    always_comb begin
        in_d    = in;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (!en) begin
            idx_d   = '0;
            valid_d = 1'b0;
        end else if (!hold) begin
            idx_d   = enc;
            valid_d = |in_q;
        end
    end

    // Scan divider and digit pointer run freely, independent of en/hold.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        ptr_d = ptr_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            ptr_d = (ptr_q == PTR_W'(DIGITS - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Display: select nibble ptr_q of the zero-extended index.
    always_comb begin
        idx_ext              = '0;
        idx_ext[IDX_W-1:0]   = idx_q;
        nibble               = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (ptr_q == PTR_W'(d)) nibble = idx_ext[d*4 +: 4];
        end
        an_d  = ~(DIGITS'(1) << ptr_q);
        seg_d = valid_q ? hex_decode(nibble) : SEG_BLANK;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            div_q   <= '0;
            ptr_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            in_q    <= in_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            div_q   <= div_d;
            ptr_q   <= ptr_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign idx   = idx_q;
    assign valid = valid_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule
